// File: rtl/dffram_ctrl_pkg.sv
// rtl/dffram_ctrl_pkg.sv - shared types, constants and address helpers for the DFFRAM burst controller
package dffram_ctrl_pkg;

    localparam int AW           = 8;
    localparam int WSIZE        = 2;
    localparam int DW           = WSIZE * 8;
    localparam int RAM_AW       = 10;
    localparam int RD_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // A wrap window needs a power-of-two beat count of at least two; anything else runs linear.
    function automatic logic wrap_len_ok(input logic [AW-1:0] len);
        logic [AW:0] beats;
        beats = {1'b0, len} + (AW+1)'(1);
        return (len != '0) && ((beats & (beats - (AW+1)'(1))) == '0);
    endfunction

    // Next word address: low bits selected by the mask roll over inside the aligned window.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                                input logic [AW-1:0] mask,
                                                input logic          wrap);
        logic [AW-1:0] inc;
        inc = addr + AW'(1);
        if (wrap) begin
            return (addr & ~mask) | (inc & mask);
        end
        return inc;
    endfunction

endpackage

// File: rtl/dffram_rd_buf.sv
// rtl/dffram_rd_buf.sv - two-entry read data buffer holding data word plus last flag
module dffram_rd_buf
    import dffram_ctrl_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic [1:0]    count,
    output logic          empty
);

    logic [DW:0] mem [RD_BUF_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  cnt;
    logic        do_push;
    logic        do_pop;

    // Guard against overflow/underflow so a stray strobe cannot corrupt the pointers.
    always_comb begin
        do_push   = push && (cnt != 2'(RD_BUF_DEPTH));
        do_pop    = pop && (cnt != 2'd0);
        head_data = mem[rd_ptr][DW-1:0];
        head_last = mem[rd_ptr][DW];
        count     = cnt;
        empty     = (cnt == 2'd0);
    end

    // Entry storage and pointer/count bookkeeping; reset flushes the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dffram_burst_ctrl.sv
// rtl/dffram_burst_ctrl.sv - burst initiator for the 256x16 DFFRAM port; DFFRAM_CTRL_WRAP_EN adds wrap bursts
module dffram_burst_ctrl
    import dffram_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [AW-1:0]     req_addr_i,
    input  logic [AW-1:0]     req_len_i,
`ifdef DFFRAM_CTRL_WRAP_EN
    input  logic              req_wrap_i,
`endif
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    input  logic [DW-1:0]     wdata_i,
    input  logic [WSIZE-1:0]  wstrb_i,
    output logic              rdata_valid_o,
    input  logic              rdata_ready_i,
    output logic [DW-1:0]     rdata_o,
    output logic              rdata_last_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              EN0,
    output logic [WSIZE-1:0]  WE0,
    output logic [RAM_AW-1:0] A0,
    output logic [DW-1:0]     Di0,
    input  logic [DW-1:0]     Do0
);

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] beats_left_q;
    logic [AW-1:0] len_mask_q;
    logic          wrap_q;
    logic          inflight_q;
    logic          inflight_last_q;
    logic          done_q;

    logic [DW-1:0] head_data;
    logic          head_last;
    logic [1:0]    buf_count;
    logic          buf_empty;

    logic          wrap_req;
    logic          req_fire;
    logic          wr_fire;
    logic          rd_avail;
    logic          rd_pop;
    logic          rd_issue;
    logic          ram_en;
    logic [2:0]    occupancy;

`ifdef DFFRAM_CTRL_WRAP_EN
    assign wrap_req = req_wrap_i;
`else
    assign wrap_req = 1'b0;
`endif

    // Handshakes, read issue throttle and RAM port drive; everything is forced quiet while rst_i is high.
    always_comb begin
        req_ready_o   = (state == IDLE) && !rst_i;
        busy_o        = (state != IDLE) && !rst_i;
        wdata_ready_o = (state == WRITE) && !rst_i;
        done_o        = done_q && !rst_i;

        rd_avail      = ((state == READ) || (state == DRAIN)) && !buf_empty && !rst_i;
        rdata_valid_o = rd_avail;
        rdata_o       = head_data;
        rdata_last_o  = rd_avail && head_last;
        rd_pop        = rd_avail && rdata_ready_i;

        req_fire      = req_valid_i && req_ready_o;
        wr_fire       = wdata_ready_o && wdata_valid_i;

        // Words already in the RAM pipe plus words parked in the buffer, less the one leaving now.
        occupancy     = {2'b00, inflight_q} + {1'b0, buf_count} - {2'b00, rd_pop};
        rd_issue      = (state == READ) && !rst_i && (occupancy < 3'd2);

        ram_en        = wr_fire || rd_issue;
        EN0           = ram_en;
        WE0           = wr_fire ? wstrb_i : '0;
        A0            = ram_en ? {{(RAM_AW-AW){1'b0}}, addr_q} : '0;
        Di0           = wr_fire ? wdata_i : '0;
    end

    // Read data returns one cycle after issue; the buffer absorbs it while the consumer stalls.
    dffram_rd_buf u_rd_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (inflight_q),
        .push_data (Do0),
        .push_last (inflight_last_q),
        .pop       (rd_pop),
        .head_data (head_data),
        .head_last (head_last),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    // Burst sequencing FSM: captures the request, walks addresses and beats, pulses done at the end.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            addr_q          <= '0;
            beats_left_q    <= '0;
            len_mask_q      <= '0;
            wrap_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (beats_left_q == '0);
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        addr_q       <= req_addr_i;
                        beats_left_q <= req_len_i;
                        len_mask_q   <= req_len_i;
                        wrap_q       <= wrap_req && wrap_len_ok(req_len_i);
                        state        <= req_write_i ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        addr_q <= next_addr(addr_q, len_mask_q, wrap_q);
                        if (beats_left_q == '0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            beats_left_q <= beats_left_q - AW'(1);
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr_q <= next_addr(addr_q, len_mask_q, wrap_q);
                        if (beats_left_q == '0) begin
                            state <= DRAIN;
                        end else begin
                            beats_left_q <= beats_left_q - AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The final word carries the last flag, so its pop also means nothing is left in flight.
                    if (rd_pop && head_last) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dffram_burst_ctrl.sv
// tb/tb_dffram_burst_ctrl.sv - self-checking bench for dffram_burst_ctrl with a behavioural DFFRAM
`timescale 1ns/1ps
module tb_dffram_burst_ctrl;
    import dffram_ctrl_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [AW-1:0]     req_addr_i;
    logic [AW-1:0]     req_len_i;
`ifdef DFFRAM_CTRL_WRAP_EN
    logic              req_wrap_i;
`endif
    logic              wdata_valid_i;
    logic              wdata_ready_o;
    logic [DW-1:0]     wdata_i;
    logic [WSIZE-1:0]  wstrb_i;
    logic              rdata_valid_o;
    logic              rdata_ready_i;
    logic [DW-1:0]     rdata_o;
    logic              rdata_last_o;
    logic              done_o;
    logic              busy_o;
    logic              EN0;
    logic [WSIZE-1:0]  WE0;
    logic [RAM_AW-1:0] A0;
    logic [DW-1:0]     Di0;
    logic [DW-1:0]     Do0;

    always #5 clk_i = ~clk_i;

    dffram_burst_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_len_i     (req_len_i),
`ifdef DFFRAM_CTRL_WRAP_EN
        .req_wrap_i    (req_wrap_i),
`endif
        .wdata_valid_i (wdata_valid_i),
        .wdata_ready_o (wdata_ready_o),
        .wdata_i       (wdata_i),
        .wstrb_i       (wstrb_i),
        .rdata_valid_o (rdata_valid_o),
        .rdata_ready_i (rdata_ready_i),
        .rdata_o       (rdata_o),
        .rdata_last_o  (rdata_last_o),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .EN0           (EN0),
        .WE0           (WE0),
        .A0            (A0),
        .Di0           (Di0),
        .Do0           (Do0)
    );

    // Behavioural 256x16 DFFRAM: byte-masked write, registered read data.
    logic [DW-1:0] ram [256];
    always @(posedge clk_i) begin
        if (EN0) begin
            for (int b = 0; b < WSIZE; b++) begin
                if (WE0[b]) ram[A0[AW-1:0]][b*8 +: 8] <= Di0[b*8 +: 8];
            end
            Do0 <= ram[A0[AW-1:0]];
        end
    end

    typedef struct {
        logic [AW-1:0]    a;
        logic [WSIZE-1:0] we;
        logic [DW-1:0]    di;
        logic             last;
        logic             wr;
    } acc_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } rd_t;

    typedef struct {
        logic             wr;
        logic [AW-1:0]    addr;
        logic [AW-1:0]    len;
        logic             wrap;
        logic [DW-1:0]    base;
        logic [WSIZE-1:0] strb;
        int               mode;
        logic [AW-1:0]    exp_last_addr;
        logic             chk_first;
        logic [DW-1:0]    exp_first;
    } vec_t;

    acc_t          acc_q [$];
    rd_t           rd_q  [$];
    vec_t          vecs  [$];
    logic [DW-1:0] model [256];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            issued = 0;
    int            popped = 0;
    int            first_valid_cyc;
    int            first_pop_cyc;
    int            last_pop_cyc;
    logic          exp_done = 1'b0;
    logic [AW-1:0] last_a;
    logic [DW-1:0] first_data;
    logic          got_first;

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                                input logic wrap, input logic [DW-1:0] base, input logic [WSIZE-1:0] strb,
                                input int mode, input logic [AW-1:0] exp_last_addr,
                                input logic chk_first, input logic [DW-1:0] exp_first);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.wrap = wrap; v.base = base; v.strb = strb;
        v.mode = mode; v.exp_last_addr = exp_last_addr; v.chk_first = chk_first; v.exp_first = exp_first;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic pop_now;
        acc_t e;
        rd_t  r;
        pop_now = rdata_valid_o && rdata_ready_i;
        check("done_o", done_o, exp_done);
        if (done_o) begin
            done_cnt++;
            check("req_ready_at_done", req_ready_o, 1);
        end
        exp_done = 1'b0;
        if (EN0) begin
            if (acc_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_access: got A0=%0h, expected no access (cycle %0d)", A0, cyc);
            end else begin
                e = acc_q.pop_front();
                check("A0", A0, {2'b00, e.a});
                check("WE0", WE0, e.we);
                check("Di0", Di0, e.di);
                last_a = A0[AW-1:0];
                if (e.wr && e.last) exp_done = 1'b1;
                if (!e.wr) begin
                    check("occupancy", (issued - popped - int'(pop_now)) < 2, 1);
                    issued++;
                end
            end
        end
        if (rdata_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pop_now) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rdata: got %0h, expected no beat (cycle %0d)", rdata_o, cyc);
            end else begin
                r = rd_q.pop_front();
                check("rdata_o", rdata_o, r.d);
                check("rdata_last_o", rdata_last_o, r.last);
                if (!got_first) first_data = rdata_o;
                got_first = 1'b1;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                if (r.last) exp_done = 1'b1;
                popped++;
            end
        end
    endtask

    task automatic step();
        #2;
        monitor();
        @(negedge clk_i);
        cyc++;
    endtask

    function automatic logic model_wrap_ok(input logic wrap, input logic [AW-1:0] len);
        int beats;
        beats = int'(len) + 1;
        return wrap && (len != 0) && ((beats & (beats - 1)) == 0);
    endfunction

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!req_ready_o && guard < 50) begin
            step();
            guard++;
        end
        if (!req_ready_o) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: got 0, expected 1 (cycle %0d)", cyc);
        end
    endtask

    task automatic push_expect(input vec_t v);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        acc_t          e;
        rd_t           r;
        w = model_wrap_ok(v.wrap, v.len);
        for (int i = 0; i <= int'(v.len); i++) begin
            if (w) a = (v.addr & ~v.len) | ((v.addr + AW'(i)) & v.len);
            else   a = v.addr + AW'(i);
            e.a = a; e.last = (i == int'(v.len)); e.wr = v.wr;
            if (v.wr) begin
                d = v.base + DW'(i);
                e.we = v.strb; e.di = d;
                for (int b = 0; b < WSIZE; b++) begin
                    if (v.strb[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
                end
            end else begin
                e.we = '0; e.di = '0;
                r.d = model[a]; r.last = e.last;
                rd_q.push_back(r);
            end
            acc_q.push_back(e);
        end
    endtask

    task automatic request(input vec_t v);
        req_valid_i = 1'b1;
        req_write_i = v.wr;
        req_addr_i  = v.addr;
        req_len_i   = v.len;
`ifdef DFFRAM_CTRL_WRAP_EN
        req_wrap_i  = v.wrap;
`endif
        first_valid_cyc = -1;
        first_pop_cyc   = -1;
        got_first       = 1'b0;
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        int   hs, d0, beat, guard, k;
        logic acc;
        wait_ready();
        push_expect(v);
        d0 = done_cnt;
        hs = cyc;
        request(v);
        if (v.wr) begin
            beat = 0; guard = 0;
            while (beat <= int'(v.len) && guard < 2000) begin
                wdata_valid_i = (v.mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                wdata_i       = v.base + DW'(beat);
                wstrb_i       = v.strb;
                acc           = wdata_valid_i && wdata_ready_o;
                step();
                if (acc) beat++;
                guard++;
            end
            wdata_valid_i = 1'b0;
        end else begin
            k = 0;
            while ((rd_q.size() > 0 || acc_q.size() > 0) && k < 3000) begin
                case (v.mode)
                    1:       rdata_ready_i = (k < 12) ? 1'(k % 2) : (k >= 17);
                    2:       rdata_ready_i = 1'($urandom_range(0, 1));
                    default: rdata_ready_i = 1'b1;
                endcase
                step();
                k++;
            end
            rdata_ready_i = 1'b1;
        end
        guard = 0;
        while (done_cnt == d0 && guard < 10) begin
            step();
            guard++;
        end
        check("done_count", done_cnt - d0, 1);
        check("beats_pending", acc_q.size() + rd_q.size(), 0);
        check("last_addr", last_a, v.exp_last_addr);
        if (v.chk_first) check("first_rdata", first_data, v.exp_first);
        if (!v.wr && v.mode == 0) begin
            check("read_latency", first_valid_cyc - hs, 3);
            check("read_streaming", last_pop_cyc - first_pop_cyc, int'(v.len));
        end
    endtask

    initial begin
        vec_t v;
        int   guard;

        vecs.push_back(mk(1, 8'h00, 8'd255, 0, 16'h0000, 2'b11, 0, 8'hFF, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h00, 8'd255, 0, 16'h0000, 2'b00, 0, 8'hFF, 1, 16'h0000));
        vecs.push_back(mk(1, 8'h10, 8'd0,   0, 16'h1234, 2'b11, 0, 8'h10, 0, 16'h0000));
        vecs.push_back(mk(1, 8'h10, 8'd0,   0, 16'hABCD, 2'b01, 0, 8'h10, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h10, 8'd0,   0, 16'h0000, 2'b00, 0, 8'h10, 1, 16'h12CD));
        vecs.push_back(mk(0, 8'h20, 8'd7,   0, 16'h0000, 2'b00, 1, 8'h27, 1, 16'h0020));
        vecs.push_back(mk(1, 8'hFE, 8'd3,   0, 16'h00A0, 2'b11, 1, 8'h01, 0, 16'h0000));
        vecs.push_back(mk(0, 8'hFE, 8'd3,   0, 16'h0000, 2'b00, 2, 8'h01, 1, 16'h00A0));
        vecs.push_back(mk(1, 8'h30, 8'd3,   0, 16'h5500, 2'b00, 0, 8'h33, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h30, 8'd3,   0, 16'h0000, 2'b00, 0, 8'h33, 1, 16'h0030));
`ifdef DFFRAM_CTRL_WRAP_EN
        vecs.push_back(mk(0, 8'h0D, 8'd7,   1, 16'h0000, 2'b00, 0, 8'h0C, 1, 16'h000D));
        vecs.push_back(mk(0, 8'h0D, 8'd5,   1, 16'h0000, 2'b00, 0, 8'h12, 1, 16'h000D));
        vecs.push_back(mk(1, 8'h05, 8'd3,   1, 16'h7700, 2'b11, 0, 8'h04, 0, 16'h0000));
        vecs.push_back(mk(0, 8'h04, 8'd3,   0, 16'h0000, 2'b00, 0, 8'h07, 1, 16'h7703));
`endif

        rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_len_i = '0;
`ifdef DFFRAM_CTRL_WRAP_EN
        req_wrap_i = 1'b0;
`endif
        wdata_valid_i = 1'b1; wdata_i = 16'hFFFF; wstrb_i = 2'b11; rdata_ready_i = 1'b1;

        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        check("rst_req_ready", req_ready_o, 0);
        check("rst_outputs", {EN0, WE0, A0, Di0, rdata_valid_o, rdata_last_o, done_o, busy_o, wdata_ready_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        check("idle_req_ready", req_ready_o, 1);
        check("idle_outputs", {EN0, WE0, A0, Di0, rdata_valid_o, rdata_last_o, done_o, busy_o, wdata_ready_o}, 0);
        @(negedge clk_i);
        wdata_valid_i = 1'b0;

        foreach (vecs[i]) run_burst(vecs[i]);

        // Reset in the middle of an 8-beat read, then a clean burst afterwards.
        v = mk(0, 8'h40, 8'd7, 0, 16'h0000, 2'b00, 0, 8'h47, 1, 16'h0040);
        wait_ready();
        push_expect(v);
        request(v);
        guard = 0;
        while (rd_q.size() > 5 && guard < 100) begin
            step();
            guard++;
        end
        check("abort_reached_beat3", rd_q.size(), 5);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        acc_q.delete();
        rd_q.delete();
        issued = 0;
        popped = 0;
        exp_done = 1'b0;
        #2;
        check("abort_en0", EN0, 0);
        check("abort_rdata_valid", rdata_valid_o, 0);
        check("abort_req_ready", req_ready_o, 1);
        check("abort_busy", busy_o, 0);
        @(negedge clk_i);
        cyc++;
        for (int i = 0; i < 6; i++) step();
        run_burst(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dffram_burst_ctrl.md
Name: dffram_burst_ctrl

Overview:
Initiator-side controller for the dffram256x16_wrap macro port (EN0/WE0/A0/Di0/Do0). It turns burst requests from the cache datapath into word-by-word RAM accesses. Write data enters on a valid/ready stream; read data leaves on a valid/ready stream with backpressure. It sits between the SPI flash line-fill engine / host read path and the 256x16 DFFRAM.

Parameters:
AW, 8, word address width (256 words)
WSIZE, 2, bytes per word (byte-enable width)
DW, WSIZE*8 = 16, data width
RAM_AW, 10, width of the RAM A0 port; upper RAM_AW-AW bits are driven 0

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  burst request valid
req_ready_o  out  1  controller idle, request accepted on valid&ready
req_write_i  in  1  1 = write burst, 0 = read burst
req_addr_i  in  AW  start word address
req_len_i  in  AW  beats minus one (0..255 gives 1..256 beats)
req_wrap_i  in  1  wrap-burst select (present only with DFFRAM_CTRL_WRAP_EN)
wdata_valid_i  in  1  write beat valid
wdata_ready_o  out  1  write beat accepted
wdata_i  in  DW  write data
wstrb_i  in  WSIZE  byte enables for the beat
rdata_valid_o  out  1  read beat valid
rdata_ready_i  in  1  consumer accepts read beat
rdata_o  out  DW  read data
rdata_last_o  out  1  final beat of the read burst
done_o  out  1  one-cycle pulse at burst completion
busy_o  out  1  state != IDLE
EN0  out  1  RAM enable
WE0  out  WSIZE  RAM byte write enables
A0  out  RAM_AW  RAM address
Di0  out  DW  RAM write data
Do0  in  DW  RAM read data, valid the cycle after the enabling edge

Behaviour:
- Reset (rst_i high at posedge): state IDLE, read buffer flushed, counters cleared. Outputs during and after reset: EN0=0, WE0=0, A0=0, Di0=0, rdata_valid_o=0, rdata_last_o=0, done_o=0, busy_o=0, wdata_ready_o=0. req_ready_o=0 while rst_i is high and 1 in IDLE afterwards.
- States: IDLE, WRITE, READ, DRAIN. IDLE -> WRITE or READ on the request handshake. Address and beat count are captured at that handshake.
- WRITE: wdata_ready_o=1. On each wdata handshake, the same cycle drives EN0=1, WE0=wstrb_i, A0={0,addr}, Di0=wdata_i. Otherwise EN0=0 and WE0=0. wstrb 2'b00 counts as a beat but writes nothing. After the final beat: done_o=1 in the next cycle, and the state returns to IDLE in that same cycle.
- READ: issues EN0=1, WE0=0, A0=addr when (inflight + buffered - pop_this_cycle) < 2. Do0 is captured into the 2-entry buffer the cycle after issue. rdata_o/rdata_valid_o come from the buffer head (registered).
- Read latency: handshake at cycle A, first issue at A+1, Do0 valid at A+2, rdata_valid_o=1 at A+3. Sustained rate is 1 beat/cycle while rdata_ready_i=1.
- READ -> DRAIN after the final issue. DRAIN -> IDLE once the buffer is empty and nothing is in flight. done_o pulses in the cycle after the last rdata handshake, and req_ready_o=1 in that same cycle (back-to-back requests allowed).
- rdata_last_o is asserted with beat req_len_i.
- Address sequencing (linear): addr+1 modulo 256 (0xFF -> 0x00).
- Outside WRITE, wdata_valid_i is ignored. Outside READ/DRAIN, rdata_valid_o=0.
- Reset mid-burst aborts immediately: pending beats are discarded and no done_o is generated.

Optional Feature:
DFFRAM_CTRL_WRAP_EN
- Defined: the req_wrap_i port exists. With req_wrap_i=1 and req_len_i+1 a power of two in 2..256, the address wraps inside an aligned window: addr_i = (start & ~len) | ((start+i) & len). A wrap request with a non-power-of-two length runs linear.
- Undefined: no port; all bursts are linear.

Decomposition:
- Package dffram_ctrl_pkg: state enum (IDLE, WRITE, READ, DRAIN), AW/WSIZE/DW/RAM_AW constants, RD_BUF_DEPTH=2.
- Sub-module dffram_rd_buf: 2-entry FIFO holding the data word plus the last flag, exposing push, pop, count, empty.

Test Plan:
1. Write burst addr 0x00, len 255, data=i, strb 11; then read burst same range with rdata_ready_i=1 -> rdata_o=i on 256 consecutive cycles starting A+3; rdata_last_o on i=255; one done_o per burst.
2. Write 0x1234 @0x10 strb 11, then 0xABCD @0x10 strb 01; read @0x10 len 0 -> 0x12CD.
3. Read 8 beats from 0x20 with rdata_ready_i toggling every cycle, then held low for 5 cycles -> exact in-order sequence with no loss or duplicate; inflight+buffered never exceeds 2.
4. Write @0xFE len 3 data 0xA0..0xA3 -> A0 sequence 0xFE, 0xFF, 0x00, 0x01; readback matches.
5. With DFFRAM_CTRL_WRAP_EN: read @0x0D len 7 wrap=1 -> A0 sequence 0D, 0E, 0F, 08, 09, 0A, 0B, 0C.
6. rst_i pulsed during beat 3 of an 8-beat read -> EN0=0 and rdata_valid_o=0 the following cycle; no done_o; req_ready_o=1 the cycle after rst_i falls; a new request completes normally.
